mandel_pixel_scheduler: RTL

//  Frame-level sequencer for the fractal iteration core. Raster-scans an H_RES x V_RES

---
 rtl/mandel_pixel_scheduler.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mandel_pixel_scheduler.sv
// Frame-level sequencer for the fractal iteration core.
// Raster-scans an H_RES x V_RES grid, walks the complex coordinate of each pixel
// by accumulation, hands one pixel at a time to the core (start/done) and writes
// the returned iteration count to the frame buffer (valid/ready).
module mandel_pixel_scheduler #(
  parameter int H_RES  = 160,
  parameter int V_RES  = 120,
  parameter int ADDR_W = 15
) (
  input  logic                     Clk_100M,
  input  logic                     Rst_n,
  input  logic                     go,
  input  logic                     abort,
  input  logic signed [15:0]       startX,
  input  logic signed [15:0]       startY,
  input  logic signed [15:0]       stepX,
  input  logic signed [15:0]       stepY,
  output logic                     core_start,
  output logic signed [15:0]       core_cx,
  output logic signed [15:0]       core_cy,
  input  logic                     core_done,
  input  logic [7:0]               core_iter,
  output logic                     pix_we,
  output logic [ADDR_W-1:0]        pix_addr,
  output logic [7:0]               pix_data,
  input  logic                     pix_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int DATA_W = 16;
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_ADVANCE, S_DONE
  } state_t;

  state_t                    state_q, state_d;
  logic signed [DATA_W-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic signed [DATA_W-1:0]  start_x_q, start_x_d;
  logic signed [DATA_W-1:0]  step_x_q, step_x_d, step_y_q, step_y_d;
  logic [XW-1:0]             x_q, x_d;
  logic [YW-1:0]             y_q, y_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [7:0]                data_q, data_d;
  logic                      core_start_q, core_start_d;
  logic                      pix_we_q, pix_we_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;

  // Next-state and registered-output computation for the pixel sequencer.
  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    start_x_d    = start_x_q;
    step_x_d     = step_x_q;
    step_y_d     = step_y_q;
    x_d          = x_q;
    y_d          = y_q;
    addr_d       = addr_q;
    data_d       = data_q;
    core_start_d = 1'b0;
    pix_we_d     = pix_we_q;
    frame_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort outranks go so a simultaneous pair leaves the block idle
        if (go && !abort) begin
          start_x_d    = startX;
          step_x_d     = stepX;
          step_y_d     = stepY;
          cx_d         = startX;
          cy_d         = startY;
          x_d          = '0;
          y_d          = '0;
          addr_d       = '0;
          core_start_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core_done) begin
          data_d   = core_iter;
          pix_we_d = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (pix_ready) begin
          pix_we_d = 1'b0;
          state_d  = S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        if (x_q == X_LAST && y_q == Y_LAST) begin
          frame_done_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (x_q == X_LAST) begin
            x_d  = '0;
            y_d  = y_q + YW'(1);
            cx_d = start_x_q;
            cy_d = cy_q - step_y_q;
          end else begin
            x_d  = x_q + XW'(1);
            cx_d = cx_q + step_x_q;
          end
          core_start_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // abort drops the frame on the next edge without any further handshakes
    if (state_q != S_IDLE && abort) begin
      state_d      = S_IDLE;
      core_start_d = 1'b0;
      pix_we_d     = 1'b0;
      frame_done_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State, coordinate accumulators, latched parameters and registered outputs.
  always_ff @(posedge Clk_100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= S_IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      start_x_q    <= '0;
      step_x_q     <= '0;
      step_y_q     <= '0;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      core_start_q <= 1'b0;
      pix_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      start_x_q    <= start_x_d;
      step_x_q     <= step_x_d;
      step_y_q     <= step_y_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      core_start_q <= core_start_d;
      pix_we_q     <= pix_we_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign core_start = core_start_q;
  assign core_cx    = cx_q;
  assign core_cy    = cy_q;
  assign pix_we     = pix_we_q;
  assign pix_addr   = addr_q;
  assign pix_data   = data_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
